// File: rtl/axi_adc_jesd204_sample_pack.sv
// Packs the samples of enabled ADC channels, sample-interleaved in ascending channel order, into full-width words.
// Optional macro ADC_PACK_WORD_COUNT_EN adds a 32-bit packed_count output.
module axi_adc_jesd204_sample_pack #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 2,
    parameter int OCT_PER_SAMPLE  = 2
) (
    input  logic                                                     adc_clk,
    input  logic                                                     adc_rstn,
    input  logic                                                     adc_valid,
    input  logic [NUM_CHANNELS-1:0]                                  adc_enable,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*8*OCT_PER_SAMPLE-1:0] adc_data,
    output logic                                                     packed_valid,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*8*OCT_PER_SAMPLE-1:0] packed_data,
    output logic                                                     packed_sync,
`ifdef ADC_PACK_WORD_COUNT_EN
    output logic [31:0]                                              packed_count,
`endif
    output logic                                                     cfg_err
);

    localparam int SW = 8 * OCT_PER_SAMPLE;
    localparam int CW = SW * DATA_PATH_WIDTH;
    localparam int OW = CW * NUM_CHANNELS;
    localparam int EW = $clog2(NUM_CHANNELS) + 1;
    localparam int FW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] en_r;
    logic                    cfg_err_r;
    logic [EW-1:0]           e_cnt_s;
    logic                    cfg_bad_s;
    logic                    cfg_ok_s;
    logic                    flush_s;
    logic [OW-1:0]           gather_s;
    logic                    s1_valid_r;
    logic [OW-1:0]           s1_block_r;
    logic [OW-1:0]           acc_r;
    logic [OW-1:0]           acc_next_s;
    logic [OW-1:0]           blk_mask_s;
    logic [31:0]             off_s;
    logic                    last_s;
    logic [FW-1:0]           fill_r;
    logic                    sync_pend_r;
    logic                    packed_valid_r;
    logic [OW-1:0]           packed_data_r;
    logic                    packed_sync_r;

    // Enabled-channel count and configuration legality.
    always_comb begin
        e_cnt_s = {EW{1'b0}};
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            e_cnt_s = e_cnt_s + EW'(en_r[n]);
        end
        cfg_bad_s = (e_cnt_s != {EW{1'b0}}) && ((e_cnt_s & (e_cnt_s - EW'(1'b1))) != {EW{1'b0}});
        cfg_ok_s  = (e_cnt_s != {EW{1'b0}}) && !cfg_bad_s;
        flush_s   = (adc_enable != en_r);
    end

    // Gather sample s of every enabled channel, for each s in turn, into a contiguous block.
    always_comb begin : gather
        int idx;
        idx      = 0;
        gather_s = {OW{1'b0}};
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                if (en_r[n]) begin
                    gather_s = gather_s | (OW'(adc_data[n*CW + s*SW +: SW]) << (idx * SW));
                    idx      = idx + 1;
                end else begin
                    idx      = idx;
                end
            end
        end
    end

    // Place the stage-1 block at the current fill slot; the word completes when R slots are filled.
    always_comb begin
        off_s      = 32'(fill_r) * 32'(e_cnt_s) * 32'(CW);
        blk_mask_s = ~({OW{1'b1}} << (32'(e_cnt_s) * 32'(CW)));
        acc_next_s = (acc_r & ~(blk_mask_s << off_s)) | ((s1_block_r & blk_mask_s) << off_s);
        last_s     = ((32'(fill_r) + 32'd1) * 32'(e_cnt_s)) >= 32'(NUM_CHANNELS);
    end

    // Enable and configuration-error registers.
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            en_r      <= {NUM_CHANNELS{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            en_r      <= adc_enable;
            cfg_err_r <= cfg_bad_s;
        end
    end

    // Stage 1: capture gathered block; beats under an illegal or changing config are dropped.
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            s1_valid_r <= 1'b0;
            s1_block_r <= {OW{1'b0}};
        end else if (flush_s) begin
            s1_valid_r <= 1'b0;
            s1_block_r <= {OW{1'b0}};
        end else begin
            s1_valid_r <= adc_valid & cfg_ok_s;
            if (adc_valid && cfg_ok_s) begin
                s1_block_r <= gather_s;
            end else begin
                s1_block_r <= s1_block_r;
            end
        end
    end

    // Stage 2: accumulate blocks and emit completed words with a one-shot sync marker.
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            acc_r          <= {OW{1'b0}};
            fill_r         <= {FW{1'b0}};
            sync_pend_r    <= 1'b1;
            packed_valid_r <= 1'b0;
            packed_data_r  <= {OW{1'b0}};
            packed_sync_r  <= 1'b0;
        end else begin
            packed_valid_r <= 1'b0;
            packed_sync_r  <= 1'b0;
            if (flush_s) begin
                acc_r       <= {OW{1'b0}};
                fill_r      <= {FW{1'b0}};
                sync_pend_r <= 1'b1;
            end else if (s1_valid_r) begin
                acc_r <= acc_next_s;
                if (last_s) begin
                    fill_r         <= {FW{1'b0}};
                    packed_data_r  <= acc_next_s;
                    packed_valid_r <= 1'b1;
                    packed_sync_r  <= sync_pend_r;
                    sync_pend_r    <= 1'b0;
                end else begin
                    fill_r <= fill_r + FW'(1'b1);
                end
            end else begin
                fill_r <= fill_r;
            end
        end
    end

`ifdef ADC_PACK_WORD_COUNT_EN
    logic [31:0] count_r;

    // Word counter: the sync word reads 0 on its own cycle, increments after each emitted word.
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            count_r <= 32'd0;
        end else if (flush_s) begin
            count_r <= 32'd0;
        end else if (packed_valid_r) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign packed_count = count_r;
`endif

    assign packed_valid = packed_valid_r;
    assign packed_data  = packed_data_r;
    assign packed_sync  = packed_sync_r;
    assign cfg_err      = cfg_err_r;

endmodule

// File: tb/tb_axi_adc_jesd204_sample_pack.sv
// Self-checking bench for axi_adc_jesd204_sample_pack: directed scenarios plus a randomized phase
// checked every cycle against a sample-queue reference model.
module tb_axi_adc_jesd204_sample_pack;

    localparam int NC   = 4;
    localparam int DPW  = 2;
    localparam int SW   = 16;
    localparam int CW   = SW * DPW;
    localparam int OW   = CW * NC;
    localparam int NE   = NC * DPW;
    localparam int MAXC = 2048;

    logic          adc_clk = 1'b0;
    logic          adc_rstn = 1'b0;
    logic          adc_valid = 1'b0;
    logic [NC-1:0] adc_enable = '0;
    logic [OW-1:0] adc_data = '0;
    logic          packed_valid;
    logic [OW-1:0] packed_data;
    logic          packed_sync;
    logic          cfg_err;
`ifdef ADC_PACK_WORD_COUNT_EN
    logic [31:0]   packed_count;
`endif

    axi_adc_jesd204_sample_pack #(
        .NUM_CHANNELS(NC), .DATA_PATH_WIDTH(DPW), .OCT_PER_SAMPLE(2)
    ) dut (
        .adc_clk(adc_clk),
        .adc_rstn(adc_rstn),
        .adc_valid(adc_valid),
        .adc_enable(adc_enable),
        .adc_data(adc_data),
        .packed_valid(packed_valid),
        .packed_data(packed_data),
        .packed_sync(packed_sync),
`ifdef ADC_PACK_WORD_COUNT_EN
        .packed_count(packed_count),
`endif
        .cfg_err(cfg_err)
    );

    always #5 adc_clk = ~adc_clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            nvalid = 0;
    bit            exp_v [MAXC];
    bit            exp_s [MAXC];
    logic [OW-1:0] exp_w [MAXC];
    bit            rst_c [MAXC];
    bit            clr   [MAXC];
    logic [NC-1:0] eff_en[MAXC];
    logic [SW-1:0] pend_q[$];
    bit            m_sync = 1'b1;
    int            m_cnt = 0;
    logic [OW-1:0] m_data = '0;

    function automatic bit bad_cfg(input logic [NC-1:0] e);
        int c;
        c = $countones(e);
        return (c != 0) && ((c & (c - 1)) != 0);
    endfunction

    function automatic bit good_cfg(input logic [NC-1:0] e);
        return ($countones(e) != 0) && !bad_cfg(e);
    endfunction

    // Channel n, sample s, beat b carries {n, s, b[7:0]}.
    function automatic logic [OW-1:0] pat(input int b);
        logic [OW-1:0] d;
        d = '0;
        for (int n = 0; n < NC; n++)
            for (int s = 0; s < DPW; s++)
                d[n*CW + s*SW +: SW] = {4'(n), 4'(s), 8'(b)};
        return d;
    endfunction

    task automatic check();
        bit   e_cfg;
        logic e_sync;
        if (rst_c[cyc-1]) m_data = '0;
        if (clr[cyc]) m_cnt = 0;
        if (exp_v[cyc]) m_data = exp_w[cyc];
        e_cfg  = rst_c[cyc-1] ? 1'b0 : ((cyc >= 2) ? bad_cfg(eff_en[cyc-2]) : 1'b0);
        e_sync = exp_v[cyc] && exp_s[cyc];
        n_cmp++;
        assert (packed_valid === exp_v[cyc]) else begin
            n_err++; $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, packed_valid, exp_v[cyc]);
        end
        n_cmp++;
        assert (packed_data === m_data) else begin
            n_err++; $error("FAIL data cyc=%0d observed=%h expected=%h", cyc, packed_data, m_data);
        end
        n_cmp++;
        assert (packed_sync === e_sync) else begin
            n_err++; $error("FAIL sync cyc=%0d observed=%b expected=%b", cyc, packed_sync, e_sync);
        end
        n_cmp++;
        assert (cfg_err === e_cfg) else begin
            n_err++; $error("FAIL cfg_err cyc=%0d observed=%b expected=%b", cyc, cfg_err, e_cfg);
        end
`ifdef ADC_PACK_WORD_COUNT_EN
        n_cmp++;
        assert (packed_count === 32'(m_cnt)) else begin
            n_err++; $error("FAIL count cyc=%0d observed=%0d expected=%0d", cyc, packed_count, m_cnt);
        end
`endif
        if (exp_v[cyc]) m_cnt++;
        if (packed_valid === 1'b1) nvalid++;
    endtask

    // Drive one cycle of inputs, update the model, advance a clock and check.
    task automatic step(input bit rstn, input bit v, input logic [NC-1:0] en, input logic [OW-1:0] d);
        logic [NC-1:0] eff;
        logic [NC-1:0] prev;
        logic [OW-1:0] w;
        adc_rstn   = rstn;
        adc_valid  = v;
        adc_enable = en;
        adc_data   = d;
        eff  = rstn ? en : '0;
        prev = (cyc > 0) ? eff_en[cyc-1] : '0;
        eff_en[cyc] = eff;
        rst_c[cyc]  = !rstn;
        if (!rstn) begin
            pend_q.delete(); m_sync = 1'b1;
            exp_v[cyc+1] = 1'b0; exp_v[cyc+2] = 1'b0; clr[cyc+1] = 1'b1;
        end else if (eff != prev) begin
            pend_q.delete(); m_sync = 1'b1;
            exp_v[cyc+1] = 1'b0; clr[cyc+1] = 1'b1;
        end else if (v && good_cfg(eff)) begin
            for (int s = 0; s < DPW; s++)
                for (int n = 0; n < NC; n++)
                    if (eff[n]) pend_q.push_back(d[n*CW + s*SW +: SW]);
            if (pend_q.size() == NE) begin
                w = '0;
                for (int i = 0; i < NE; i++) w[i*SW +: SW] = pend_q[i];
                exp_v[cyc+2] = 1'b1; exp_w[cyc+2] = w; exp_s[cyc+2] = m_sync;
                m_sync = 1'b0;
                pend_q.delete();
            end
        end
        @(posedge adc_clk);
        #1;
        cyc++;
        check();
    endtask

    task automatic idle(input int n, input logic [NC-1:0] en);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, en, '0);
    endtask

    task automatic expect_words(input string tag, input int v0, input int want);
        n_cmp++;
        assert (nvalid - v0 == want) else begin
            n_err++; $error("FAIL %s words observed=%0d expected=%0d", tag, nvalid - v0, want);
        end
    endtask

    initial begin
        int v0;
        logic [NC-1:0] en;
        logic [NC-1:0] en_list [10];
        en_list = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                    4'b0101, 4'b1100, 4'b1111, 4'b0111, 4'b0000};

        step(1'b0, 1'b0, 4'b1111, '0);
        step(1'b0, 1'b0, 4'b1111, '0);
        idle(2, 4'b1111);

        // All channels: one word per beat, first carries sync.
        v0 = nvalid;
        for (int b = 0; b < 6; b++) step(1'b1, 1'b1, 4'b1111, pat(b));
        idle(3, 4'b1111);
        expect_words("all_ch", v0, 6);

        // Single channel: four beats make one word.
        idle(2, 4'b0001);
        v0 = nvalid;
        for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 4'b0001, pat(b));
        idle(3, 4'b0001);
        expect_words("one_ch", v0, 1);

        // Two channels with gaps.
        idle(2, 4'b0101);
        v0 = nvalid;
        for (int b = 0; b < 4; b++) begin
            step(1'b1, 1'b1, 4'b0101, pat(b));
            step(1'b1, 1'b0, 4'b0101, '0);
        end
        idle(3, 4'b0101);
        expect_words("two_ch_gaps", v0, 2);

        // Illegal three-channel config, then recovery.
        idle(2, 4'b0111);
        n_cmp++;
        assert (cfg_err === 1'b1) else begin
            n_err++; $error("FAIL cfg_err_set observed=%b expected=1", cfg_err);
        end
        v0 = nvalid;
        for (int b = 0; b < 20; b++) step(1'b1, 1'b1, 4'b0111, pat(b));
        idle(2, 4'b0111);
        expect_words("bad_cfg", v0, 0);
        idle(2, 4'b0011);
        n_cmp++;
        assert (cfg_err === 1'b0) else begin
            n_err++; $error("FAIL cfg_err_clr observed=%b expected=0", cfg_err);
        end
        for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 4'b0011, pat(b));
        idle(3, 4'b0011);

        // Reconfiguration mid-word discards the partial word; change-cycle beat is dropped.
        idle(2, 4'b0001);
        v0 = nvalid;
        step(1'b1, 1'b1, 4'b0001, pat(0));
        step(1'b1, 1'b1, 4'b0001, pat(1));
        step(1'b1, 1'b1, 4'b0011, pat(2));
        step(1'b1, 1'b1, 4'b0011, pat(3));
        step(1'b1, 1'b1, 4'b0011, pat(4));
        idle(3, 4'b0011);
        expect_words("reconfig", v0, 1);

        // Reset mid-word.
        idle(2, 4'b0001);
        for (int b = 0; b < 3; b++) step(1'b1, 1'b1, 4'b0001, pat(b));
        step(1'b0, 1'b0, 4'b0001, '0);
        n_cmp++;
        assert (packed_data === '0 && packed_valid === 1'b0 && packed_sync === 1'b0 && cfg_err === 1'b0) else begin
            n_err++; $error("FAIL reset_outputs observed=%b%b%b data=%h expected=000 data=0",
                            packed_valid, packed_sync, cfg_err, packed_data);
        end
        idle(1, 4'b0001);
        v0 = nvalid;
        for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 4'b0001, pat(b + 8));
        idle(3, 4'b0001);
        expect_words("after_reset", v0, 1);

        // Randomized phase.
        en = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) en = en_list[$urandom_range(9)];
            if ($urandom_range(99) == 0)
                step(1'b0, 1'b0, en, '0);
            else
                step(1'b1, ($urandom_range(3) != 0), en, {$urandom, $urandom, $urandom, $urandom});
        end
        idle(4, en);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_adc_jesd204_sample_pack.md
Name: axi_adc_jesd204_sample_pack

Overview:
- Downstream of the per-channel ADC JESD204 datapath; consumes formatted per-channel sample words and channel enables.
- Packs the samples of enabled channels, sample-interleaved and in ascending channel order, into full-width output words for the DMA/FIFO interface.
- Accumulates several input beats into one output word when fewer than all channels are enabled; emits a sync marker after every reconfiguration.

Parameters:
- NUM_CHANNELS, 4, number of channels; must be a power of two, at least 1.
- DATA_PATH_WIDTH, 2, samples per channel per clock.
- OCT_PER_SAMPLE, 2, octets per formatted sample. Derived widths: SW = 8*OCT_PER_SAMPLE, CW = SW*DATA_PATH_WIDTH, OW = CW*NUM_CHANNELS.

Ports:
- adc_clk  in  1  datapath clock.
- adc_rstn  in  1  reset, synchronous, active-low.
- adc_valid  in  1  input beat qualifier.
- adc_enable  in  NUM_CHANNELS  per-channel enable; bit n belongs to channel n.
- adc_data  in  OW  channel n occupies [n*CW +: CW]; sample s of channel n is [n*CW + s*SW +: SW].
- packed_valid  out  1  one-cycle qualifier for packed_data.
- packed_data  out  OW  packed word.
- packed_sync  out  1  qualifies the first packed word after reset or a reconfiguration.
- cfg_err  out  1  high while the enabled-channel count is not a power of two.

Behaviour:
- Clock and reset: one clock, adc_clk; reset adc_rstn is synchronous, active-low.
- Reset values: packed_valid=0, packed_data=0, packed_sync=0, cfg_err=0, fill counter=0, registered enable=0, sync-pending=1.
- Enable register: adc_enable is registered every cycle.
  - E = popcount of the registered enable. R = NUM_CHANNELS/E.
  - cfg_err = 1 when E is not a power of two (E=0 is not an error), updated one cycle after the enable register.
- Gather stage (stage 1, registered): on adc_valid, build an E*CW block ordered as: for s = 0..DATA_PATH_WIDTH-1, for each enabled channel in ascending index, take sample s. Element k of the block sits at [k*SW +: SW].
- Accumulate stage (stage 2): the gathered block is written to [fill*E*CW +: E*CW] of the accumulator, then fill increments.
  - When fill reaches R-1, the completed word moves to packed_data, packed_valid is pulsed high for 1 cycle, and fill wraps to 0.
- Latency: packed_valid is asserted 2 cycles after the adc_valid beat that completes the word. With all channels enabled, R=1 and every beat produces one word.
- Gaps: adc_valid low holds all state; there is no timeout and no padding.
- Reconfiguration: a registered-enable change flushes the pipeline.
  - Stage-1 content and the partial accumulator are discarded, fill is forced to 0 and sync-pending is set.
  - Beats arriving in the change cycle are dropped.
- packed_sync is asserted with the first packed_valid while sync-pending is set; sync-pending is cleared at that point.
- No output is produced when E=0 or cfg_err=1; input beats are dropped and fill stays 0.
- packed_data holds its last value while packed_valid is low.
- Reset asserted mid-word: the partial word is discarded, and the next output after reset carries packed_sync=1.
- No backpressure: the consumer must accept packed_valid unconditionally.

Optional Feature:
- Macro: ADC_PACK_WORD_COUNT_EN.
- Defined: adds output packed_count [31:0].
  - Increments on every packed_valid and wraps from 2^32-1 to 0.
  - Cleared by reset and by reconfiguration flush.
  - The word carrying packed_sync gets count value 0 on its own cycle, and packed_count reads 1 afterward.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use defaults (4 channels, DPW=2, 16-bit samples). Channel n, sample s, beat b carries 16'h{n,s,b[7:0]} (4 bits, 4 bits, 8 bits).
- Enable 4'b1111, continuous valid from beat 0 -> first packed_valid 2 cycles after beat 0, with packed_sync=1 and samples ordered c0s0,c1s0,c2s0,c3s0,c0s1,...,c3s1; one word per beat thereafter with packed_sync=0.
- Enable 4'b0001, beats 0..3 -> exactly one packed_valid, containing c0s0b0,c0s1b0,c0s0b1,...,c0s1b3 from LSB.
- Enable 4'b0101, valid every other cycle, 4 beats -> 2 words, each c0s0,c2s0,c0s1,c2s1 for beat k then k+1; packed_valid never high for 2 consecutive cycles.
- Enable 4'b0111 -> cfg_err=1 and no packed_valid over 20 beats. Then enable 4'b0011 -> cfg_err=0, and the next word has packed_sync=1.
- Enable 4'b0001, 2 beats, then switch to 4'b0011 -> the partial word is never emitted; the first 4'b0011 word starts at the first post-change accepted beat with packed_sync=1.
- adc_rstn low for 1 cycle after 3 beats with 4'b0001 -> all outputs read 0 on the next cycle; 4 new beats produce one word with packed_sync=1. With ADC_PACK_WORD_COUNT_EN defined, packed_count then reads 1.
